// File: rtl/debounce_multi.sv
// debounce_multi
//   Multi-channel switch/input debouncer. Each channel has its own
//   synchroniser chain, a consecutive-mismatch counter and a registered
//   output level. A channel commits to a new level once the synchronised
//   input has disagreed with the output for threshold+1 consecutive cycles.
//   The commit cycle raises a one-cycle rise or fall pulse for that channel.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high; clears every flop
//   data_in        raw asynchronous inputs, bit i = channel i
//   threshold      required consecutive mismatch cycles minus one (quasi-static)
//   data_debounced debounced level per channel
//   rise_pulse     one-cycle pulse when a channel's output goes 0->1
//   fall_pulse     one-cycle pulse when a channel's output goes 1->0
//   any_change     registered OR of all rise/fall events, aligned with the pulses

module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  data_in,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic [CHANNELS-1:0]  data_debounced,
  output logic [CHANNELS-1:0]  rise_pulse,
  output logic [CHANNELS-1:0]  fall_pulse,
  output logic                 any_change
);

  logic [CHANNELS-1:0]  sync_chain [SYNC_STAGES];
  logic [CNT_WIDTH-1:0] cnt        [CHANNELS];
  logic [CHANNELS-1:0]  sync_lvl;
  logic [CHANNELS-1:0]  mismatch;
  logic [CHANNELS-1:0]  commit;

  assign sync_lvl = sync_chain[SYNC_STAGES-1];

  // The >= compare lets a threshold lowered mid-count commit on the very
  // next mismatch cycle; it also bounds cnt at threshold so it never wraps.
  always_comb begin
    mismatch = sync_lvl ^ data_debounced;
    commit   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      commit[i] = mismatch[i] && (cnt[i] >= threshold);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_chain[s] <= '0;
      end
    end else begin
      sync_chain[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_chain[s] <= sync_chain[s-1];
      end
    end
  end

  // Any cycle where the input agrees with the output restarts qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!mismatch[i] || commit[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Pulses are registered alongside the output so they are high exactly in
  // the cycle where data_debounced first shows the new level. A reset-driven
  // drop of the output clears everything and so never produces a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_debounced <= '0;
      rise_pulse     <= '0;
      fall_pulse     <= '0;
      any_change     <= 1'b0;
    end else begin
      data_debounced <= (data_debounced & ~commit) | (sync_lvl & commit);
      rise_pulse     <= commit & sync_lvl;
      fall_pulse     <= commit & ~sync_lvl;
      any_change     <= |commit;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
//   Directed bench for debounce_multi (4 channels, 16-bit counters, 2 sync
//   stages). Inputs change 1 ns after a rising edge; outputs are sampled
//   1 ns after each rising edge and compared with hand-computed values.

module tb_debounce_multi;

  logic        clk;
  logic        reset;
  logic [3:0]  data_in;
  logic [15:0] threshold;
  logic [3:0]  data_debounced;
  logic [3:0]  rise_pulse;
  logic [3:0]  fall_pulse;
  logic        any_change;

  int checks = 0;
  int errors = 0;
  logic [3:0] cur_deb;

  debounce_multi #(
    .CHANNELS   (4),
    .CNT_WIDTH  (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .threshold     (threshold),
    .data_debounced(data_debounced),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .any_change    (any_change)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] snap();
    return {data_debounced, rise_pulse, fall_pulse, any_change};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // n edges during which the output must hold cur_deb with no pulses
  task automatic wait_quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk(tag, snap(), {cur_deb, 9'b0});
    end
  endtask

  // one commit edge with the given pulses, then one edge with pulses cleared
  task automatic check_commit(input string tag, input logic [3:0] d,
                              input logic [3:0] r, input logic [3:0] f);
    @(posedge clk); #1;
    chk(tag, snap(), {d, r, f, |(r | f)});
    cur_deb = d;
    @(posedge clk); #1;
    chk({tag, "_after"}, snap(), {d, 9'b0});
  endtask

  // commit expected on the n-th edge counting the first edge after the change
  task automatic expect_commit(input string tag, input int n, input logic [3:0] d,
                               input logic [3:0] r, input logic [3:0] f);
    wait_quiet({tag, "_wait"}, n - 1);
    check_commit(tag, d, r, f);
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = 4'b0000;
    threshold = 16'd3;
    cur_deb   = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", snap(), 13'b0);
    reset = 1'b0;
    wait_quiet("idle_after_reset", 20);

    // clean press and release on ch0
    data_in = 4'b0001;
    expect_commit("press_ch0", 6, 4'b0001, 4'b0001, 4'b0000);
    data_in = 4'b0000;
    expect_commit("release_ch0", 6, 4'b0000, 4'b0000, 4'b0001);

    // bounce: three-cycle runs are one short of qualifying
    for (int p = 0; p < 4; p++) begin
      data_in[0] = ~p[0];
      wait_quiet("bounce", 3);
    end
    data_in[0] = 1'b1;
    expect_commit("bounce_settle", 6, 4'b0001, 4'b0001, 4'b0000);
    data_in[0] = 1'b0;
    expect_commit("bounce_release", 6, 4'b0000, 4'b0000, 4'b0001);

    // concurrency: ch2 up first, then ch1/ch3 rise while ch2 falls
    data_in = 4'b0100;
    expect_commit("ch2_rise", 6, 4'b0100, 4'b0100, 4'b0000);
    data_in = 4'b1010;
    expect_commit("concurrent", 6, 4'b1010, 4'b1010, 4'b0100);

    // threshold 0: commit on the first mismatch cycle
    threshold = 16'd0;
    data_in   = 4'b1011;
    expect_commit("thr0_rise", 3, 4'b1011, 4'b0001, 4'b0000);

    // threshold lowered from 100 to 5 while ch0 count is 50
    threshold = 16'd100;
    data_in   = 4'b1010;
    wait_quiet("thr100_count", 52);
    threshold = 16'd5;
    check_commit("thr_lowered", 4'b1010, 4'b0000, 4'b0001);

    // reset mid-count on a falling ch0
    threshold = 16'd3;
    data_in   = 4'b1011;
    expect_commit("pre_reset_rise", 6, 4'b1011, 4'b0001, 4'b0000);
    data_in = 4'b1010;
    wait_quiet("falling_cnt2", 4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", snap(), 13'b0);
    cur_deb = 4'b0000;
    data_in = 4'b0001;
    @(posedge clk); #1;
    chk("held_reset", snap(), 13'b0);
    reset = 1'b0;
    expect_commit("rise_after_reset", 6, 4'b0001, 4'b0001, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel debouncer for mechanical switches and slow asynchronous control inputs. Each channel has its own metastability synchroniser, consecutive-mismatch counter and registered output, with one-cycle rise/fall event pulses per channel. The stable-count threshold is a run-time input, so firmware can tune debounce time without a rebuild. It sits between board-level inputs and the control FSMs, and replaces the single-channel fixed-count debouncer.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- CNT_WIDTH, 16: width of each mismatch counter and of `threshold`.
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- data_in  input  CHANNELS  raw asynchronous inputs, bit i = channel i.
- threshold  input  CNT_WIDTH  required consecutive mismatch cycles minus one; quasi-static.
- data_debounced  output  CHANNELS  debounced level per channel.
- rise_pulse  output  CHANNELS  one-cycle pulse when channel i's output goes 0→1.
- fall_pulse  output  CHANNELS  one-cycle pulse when channel i's output goes 1→0.
- any_change  output  1  registered OR of all rise/fall events, coincident with the pulses.

## Operation
- Per channel i, a SYNC_STAGES-deep shift chain samples data_in[i]. Its last stage is `sync[i]`.
- Counter cnt[i] (CNT_WIDTH bits) behaves as follows each cycle:
  - sync[i] == data_debounced[i]: cnt[i] ← 0. Any bounce back to the stable level restarts qualification.
  - sync[i] != data_debounced[i] and cnt[i] ≥ threshold: data_debounced[i] ← sync[i], cnt[i] ← 0. Fire rise_pulse[i] if the new level is 1, fall_pulse[i] if it is 0.
  - sync[i] != data_debounced[i] and cnt[i] < threshold: cnt[i] ← cnt[i] + 1.
- The `≥` compare covers a threshold lowered mid-count: the channel commits on the next mismatch cycle. The counter never wraps.
- threshold = 0: the output commits after a single mismatch cycle.
- threshold = all ones: 2^CNT_WIDTH mismatch cycles are required.
- Channels are fully independent. Several channels may commit in the same cycle, and each raises its own pulse.
- rise_pulse/fall_pulse are registered. They are high exactly in the cycle where data_debounced shows the new value, and low in all other cycles. rise_pulse[i] and fall_pulse[i] are never high together.
- any_change is high in a cycle iff some bit of rise_pulse or fall_pulse is high in that cycle.

## Timing
- Reset (async assert, release synchronous to clk). All of the following are 0: synchroniser flops, cnt, data_debounced, rise_pulse, fall_pulse, any_change.
- An input level of 1 present at reset release is treated as a change. It qualifies normally and produces a rise_pulse.
- Latency: data_in changes and stays stable before edge E0. data_debounced and the pulse update at edge E0 + SYNC_STAGES + threshold. That is SYNC_STAGES + threshold + 1 edges counting E0.
- A mismatch run of threshold cycles or fewer (as seen at sync) produces no output change and no pulse.
- Reset asserted mid-count: the count is abandoned and all outputs go to 0 immediately. No pulse is generated for the reset-induced output drop.
- threshold is sampled every cycle with no internal register. Changing it only affects the compare.

## Test plan
- Reset values: SYNC_STAGES=2, threshold=3, data_in=0, reset pulse. Required: all outputs 0. They stay 0 for 20 cycles with no pulses.
- Clean press, ch0: data_in[0] 0→1 held. Required: data_debounced[0]=1 exactly 6 edges after the change (2+3+1), with rise_pulse[0] and any_change high for that one cycle only. Release 1→0 gives a matching fall_pulse[0].
- Bounce rejection, threshold=3: data_in[0] toggles 1,0,1,0 with 3-cycle highs, then holds 1. Required: no pulse during the bounce. The output rises 6 edges after the final stable 1.
- Concurrency: ch1 and ch3 rise in the same cycle while ch2 falls from 1. Required: rise_pulse=4'b1010 and fall_pulse=4'b0100 in the same cycle, with a single-cycle any_change.
- Threshold edge cases: threshold=0 gives output 3 edges after the change. Lowering threshold from 100 to 5 while cnt=50 commits on the next mismatch cycle.
- Reset mid-operation: ch0 at 1, reset asserted while ch0 is falling with cnt=2. Required: outputs 0 asynchronously with no pulse. After release with data_in[0]=1, rise_pulse[0] appears 6 edges later.
